// File: rtl/mult_rr_scheduler_pkg.sv
// Shared constants for the round-robin multiplier scheduler: default widths
// and FSM state encodings.
package mult_pkg;

    localparam int unsigned DEF_W     = 8;
    localparam int unsigned DEF_N_REQ = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request/response bundle between requester front ends, the scheduler and
// the product consumer.
interface mult_rr_scheduler_if
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned IDW   = $clog2(N_REQ)
);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_md;
    logic [N_REQ*W-1:0] req_mr;
    logic [N_REQ-1:0]   req_ready;
    logic               busy;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [2*W-1:0]     rsp_product;

    modport master (
        output req_valid, req_md, req_mr, rsp_ready,
        input  req_ready, busy, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_md, req_mr, rsp_ready,
        output req_ready, busy, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/mult_rr_scheduler_core.sv
// Sequential shift-add multiplier datapath: one partial product per step,
// with an iteration counter flagging the final step.
module shift_add_core
    import mult_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   md,
    input  logic [W-1:0]   mr,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int unsigned PW   = 2 * W;
    localparam int unsigned CNTW = $clog2(W + 1);

    logic [PW-1:0]   md_sh_q, md_sh_d;
    logic [W-1:0]    mr_sh_q, mr_sh_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Load wins over step; a step adds the shifted multiplicand when mr LSB is set.
    always_comb begin
        md_sh_d = md_sh_q;
        mr_sh_d = mr_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (load) begin
            md_sh_d = PW'(md);
            mr_sh_d = mr;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (step) begin
            acc_d   = acc_q + (mr_sh_q[0] ? md_sh_q : '0);
            md_sh_d = md_sh_q << 1;
            mr_sh_d = mr_sh_q >> 1;
            cnt_d   = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_sh_q <= '0;
            mr_sh_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            md_sh_q <= md_sh_d;
            mr_sh_q <= mr_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = acc_q;
    assign last    = (cnt_q == CNTW'(W - 1));

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one shift-add multiplier among N_REQ requesters: round-robin grant,
// fixed W-step run, product held until the consumer takes it.
module mult_rr_scheduler
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input logic                clk,
    input logic                reset,
    mult_rr_scheduler_if.slave bus
);

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] grant_c;
    logic [IDW-1:0]   winner_c, idx_c;
    logic             found_c;
    logic [W-1:0]     md_sel_c, mr_sel_c;
    logic             load_c, step_c, last_c;
    logic [2*W-1:0]   product_c;

    // First valid requester scanning upward from rr_ptr, wrapping at N_REQ.
    always_comb begin
        grant_c  = '0;
        winner_c = '0;
        idx_c    = '0;
        found_c  = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_c = IDW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!found_c && bus.req_valid[idx_c]) begin
                found_c        = 1'b1;
                grant_c[idx_c] = 1'b1;
                winner_c       = idx_c;
            end
        end
    end

    always_comb begin
        md_sel_c = '0;
        mr_sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                md_sel_c = bus.req_md[i*W +: W];
                mr_sel_c = bus.req_mr[i*W +: W];
            end
        end
    end

    assign bus.req_ready = (reset && state_q == ST_IDLE) ? grant_c : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        load_c      = 1'b0;
        step_c      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|(bus.req_valid & bus.req_ready)) begin
                    load_c   = 1'b1;
                    rsp_id_d = winner_c;
                    rr_ptr_d = (winner_c == IDW'(N_REQ - 1)) ? '0 : winner_c + IDW'(1);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    rsp_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    shift_add_core #(.W(W)) u_core (
        .clk     (clk),
        .rst_n   (reset),
        .load    (load_c),
        .step    (step_c),
        .md      (md_sel_c),
        .mr      (mr_sel_c),
        .product (product_c),
        .last    (last_c)
    );

    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = product_c;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler: expected id/product pushed at
// stimulus time, popped against responses logged at handshake.
module tb_mult_rr_scheduler;
    import mult_pkg::*;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned W     = 8;
    localparam int unsigned IDW   = 2;
    localparam int unsigned PW    = 2 * W;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [PW-1:0]  product;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_rr_scheduler_if #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) bus ();

    mult_rr_scheduler #(.N_REQ(N_REQ), .W(W), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N_REQ-1:0] rv;
    logic [W-1:0]     md_a [N_REQ];
    logic [W-1:0]     mr_a [N_REQ];
    assign bus.req_valid = rv;
    for (genvar g = 0; g < N_REQ; g++) begin : g_pack
        assign bus.req_md[g*W +: W] = md_a[g];
        assign bus.req_mr[g*W +: W] = mr_a[g];
    end

    rsp_t exp_q[$];
    rsp_t rsp_log[$];
    int   grant_log[$];
    int   acc_cyc_log[$];
    int   rise_log[$];
    int   cyc = 0;
    logic rv_prev = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder: accepts, rsp_valid rises and response handshakes.
    always @(negedge clk) begin
        if (!reset) begin
            rv_prev = 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    grant_log.push_back(i);
                    acc_cyc_log.push_back(cyc);
                end
            end
            if (bus.rsp_valid && !rv_prev) rise_log.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_t r;
                r.id      = bus.rsp_id;
                r.product = bus.rsp_product;
                rsp_log.push_back(r);
            end
            rv_prev = bus.rsp_valid;
        end
    end

    function automatic rsp_t mk_rsp(input int id, input logic [W-1:0] md, input logic [W-1:0] mr);
        rsp_t r;
        r.id      = IDW'(id);
        r.product = PW'(md) * PW'(mr);
        return r;
    endfunction

    function automatic rsp_t pop_obs();
        rsp_t r = '1;
        if (rsp_log.size() > 0) r = rsp_log.pop_front();
        return r;
    endfunction

    function automatic rsp_t pop_exp();
        rsp_t r = '0;
        if (exp_q.size() > 0) r = exp_q.pop_front();
        return r;
    endfunction

    function automatic int latency(input int k);
        if (rise_log.size() > k && acc_cyc_log.size() > k) return rise_log[k] - acc_cyc_log[k];
        return -1;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        exp_q.delete();
        rsp_log.delete();
        grant_log.delete();
        acc_cyc_log.delete();
        rise_log.delete();
    endtask

    task automatic set_req(input int id, input logic [W-1:0] md, input logic [W-1:0] mr);
        md_a[IDW'(id)] = md;
        mr_a[IDW'(id)] = mr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rv    = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic wait_grants(input int n, output bit to);
        int b = 0;
        while (grant_log.size() < n && b < 300) begin
            tick(1);
            b++;
        end
        to = (grant_log.size() < n);
    endtask

    task automatic wait_rsps(input int n, output bit to);
        int b = 0;
        while (rsp_log.size() < n && b < 300) begin
            tick(1);
            b++;
        end
        to = (rsp_log.size() < n);
    endtask

    task automatic issue_one(input int id, input logic [W-1:0] md, input logic [W-1:0] mr, output bit to);
        bit t1, t2;
        clear_logs();
        set_req(id, md, mr);
        exp_q.push_back(mk_rsp(id, md, mr));
        rv[IDW'(id)] = 1'b1;
        wait_grants(1, t1);
        rv = '0;
        wait_rsps(1, t2);
        to = t1 | t2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rv    = '1;
        for (int i = 0; i < N_REQ; i++) set_req(i, W'(i + 5), W'(i + 9));
        tick(2);
        n_checks++; if (bus.req_ready !== '0) $display("FAIL reset_req_ready got %b want 0", bus.req_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_id !== '0) $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); else n_pass++;
        n_checks++; if (bus.rsp_product !== '0) $display("FAIL reset_rsp_product got %0d want 0", bus.rsp_product); else n_pass++;
        rv    = '0;
        reset = 1'b1;
        tick(1);
        clear_logs();
    endtask

    task automatic test_single();
        bit t1, t2;
        rsp_t e, o;
        clear_logs();
        bus.rsp_ready = 1'b1;
        set_req(0, 8'd13, 8'd11);
        exp_q.push_back(mk_rsp(0, 8'd13, 8'd11));
        rv[0] = 1'b1;
        wait_grants(1, t1);
        rv = '0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_busy got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.req_ready !== '0) $display("FAIL single_ready_in_run got %b want 0", bus.req_ready); else n_pass++;
        wait_rsps(1, t2);
        n_checks++; if (t1 | t2) $display("FAIL single_timeout got timeout want response"); else n_pass++;
        e = pop_exp();
        o = pop_obs();
        n_checks++; if (o.product !== e.product) $display("FAIL single_product got %0d want %0d", o.product, e.product); else n_pass++;
        n_checks++; if (o.id !== e.id) $display("FAIL single_id got %0d want %0d", o.id, e.id); else n_pass++;
        n_checks++; if (latency(0) !== int'(W) + 1) $display("FAIL single_latency got %0d want %0d", latency(0) - 1, W); else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [W-1:0] md_t [4] = '{8'd255, 8'd0, 8'd200, 8'd1};
        logic [W-1:0] mr_t [4] = '{8'd255, 8'd200, 8'd0, 8'd1};
        bit to;
        rsp_t e, o;
        for (int k = 0; k < 4; k++) begin
            issue_one(0, md_t[k], mr_t[k], to);
            e = pop_exp();
            o = pop_obs();
            n_checks++; if (to) $display("FAIL bound%0d_timeout got timeout want response", k); else n_pass++;
            n_checks++; if (o !== e) $display("FAIL bound%0d_rsp got id=%0d prod=%0d want id=%0d prod=%0d", k, o.id, o.product, e.id, e.product); else n_pass++;
            n_checks++; if (latency(0) !== int'(W) + 1) $display("FAIL bound%0d_latency got %0d want %0d", k, latency(0) - 1, W); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] md_t [4] = '{8'd3, 8'd17, 8'd100, 8'd250};
        logic [W-1:0] mr_t [4] = '{8'd5, 8'd9, 8'd200, 8'd77};
        int order [5] = '{0, 1, 2, 3, 0};
        bit t1, t2;
        rsp_t e, o;
        do_reset();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, md_t[i], mr_t[i]);
        for (int k = 0; k < 5; k++) exp_q.push_back(mk_rsp(order[k], md_t[order[k]], mr_t[order[k]]));
        rv = '1;
        wait_grants(5, t1);
        rv = '0;
        wait_rsps(5, t2);
        tick(W + 4);
        n_checks++; if (t1 | t2) $display("FAIL rr_timeout got timeout want 5 responses"); else n_pass++;
        n_checks++; if (grant_log.size() !== 5) $display("FAIL rr_grant_count got %0d want 5", grant_log.size()); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            int g = (grant_log.size() > k) ? grant_log[k] : -1;
            e = pop_exp();
            o = pop_obs();
            n_checks++; if (g !== order[k]) $display("FAIL rr_grant%0d got %0d want %0d", k, g, order[k]); else n_pass++;
            n_checks++; if (o !== e) $display("FAIL rr_rsp%0d got id=%0d prod=%0d want id=%0d prod=%0d", k, o.id, o.product, e.id, e.product); else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            int sp = (acc_cyc_log.size() > k + 1) ? acc_cyc_log[k+1] - acc_cyc_log[k] : -1;
            n_checks++; if (sp !== int'(W) + 2) $display("FAIL rr_spacing%0d got %0d want %0d", k, sp, W + 2); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit t1;
        int b = 0;
        rsp_t e, o;
        clear_logs();
        bus.rsp_ready = 1'b0;
        set_req(1, 8'd100, 8'd3);
        exp_q.push_back(mk_rsp(1, 8'd100, 8'd3));
        e = exp_q[0];
        rv[1] = 1'b1;
        wait_grants(1, t1);
        rv = '0;
        while (rise_log.size() == 0 && b < 300) begin
            tick(1);
            b++;
        end
        n_checks++; if (t1 || rise_log.size() == 0) $display("FAIL bp_timeout got timeout want rsp_valid"); else n_pass++;
        set_req(2, 8'd9, 8'd9);
        rv[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid%0d got %b want 1", c, bus.rsp_valid); else n_pass++;
            n_checks++; if (bus.rsp_product !== e.product) $display("FAIL bp_product%0d got %0d want %0d", c, bus.rsp_product, e.product); else n_pass++;
            n_checks++; if (bus.rsp_id !== e.id) $display("FAIL bp_id%0d got %0d want %0d", c, bus.rsp_id, e.id); else n_pass++;
            n_checks++; if (bus.req_ready !== '0) $display("FAIL bp_req_ready%0d got %b want 0", c, bus.req_ready); else n_pass++;
        end
        bus.rsp_ready = 1'b1;
        rv = '0;
        tick(3);
        n_checks++; if (rsp_log.size() !== 1) $display("FAIL bp_rsp_count got %0d want 1", rsp_log.size()); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_valid_cleared got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (grant_log.size() !== 1) $display("FAIL bp_grant_count got %0d want 1", grant_log.size()); else n_pass++;
        e = pop_exp();
        o = pop_obs();
        n_checks++; if (o !== e) $display("FAIL bp_rsp got id=%0d prod=%0d want id=%0d prod=%0d", o.id, o.product, e.id, e.product); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit t1, to;
        rsp_t e, o;
        clear_logs();
        bus.rsp_ready = 1'b1;
        set_req(3, 8'd50, 8'd50);
        rv[3] = 1'b1;
        wait_grants(1, t1);
        rv = '0;
        tick(3);
        n_checks++; if (t1 || bus.busy !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", bus.busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid got %b want 0", bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_id !== '0) $display("FAIL abort_rsp_id got %0d want 0", bus.rsp_id); else n_pass++;
        n_checks++; if (bus.rsp_product !== '0) $display("FAIL abort_rsp_product got %0d want 0", bus.rsp_product); else n_pass++;
        n_checks++; if (bus.req_ready !== '0) $display("FAIL abort_req_ready got %b want 0", bus.req_ready); else n_pass++;
        tick(2);
        reset = 1'b1;
        tick(W + 4);
        n_checks++; if (rise_log.size() !== 0) $display("FAIL abort_no_rsp got %0d rises want 0", rise_log.size()); else n_pass++;
        issue_one(2, 8'd7, 8'd9, to);
        e = pop_exp();
        o = pop_obs();
        n_checks++; if (to) $display("FAIL abort_after_timeout got timeout want response"); else n_pass++;
        n_checks++; if (o !== e) $display("FAIL abort_after_rsp got id=%0d prod=%0d want id=%0d prod=%0d", o.id, o.product, e.id, e.product); else n_pass++;
    endtask

    task automatic test_wrap();
        bit t1, t2, t3;
        rsp_t e, o;
        do_reset();
        bus.rsp_ready = 1'b1;
        set_req(3, 8'd21, 8'd4);
        set_req(1, 8'd33, 8'd6);
        exp_q.push_back(mk_rsp(3, 8'd21, 8'd4));
        exp_q.push_back(mk_rsp(1, 8'd33, 8'd6));
        rv[3] = 1'b1;
        wait_grants(1, t1);
        rv[1] = 1'b1;
        wait_grants(2, t2);
        rv = '0;
        wait_rsps(2, t3);
        n_checks++; if (t1 | t2 | t3) $display("FAIL wrap_timeout got timeout want 2 responses"); else n_pass++;
        n_checks++; if (grant_log.size() < 1 || grant_log[0] !== 3) $display("FAIL wrap_grant0 got %0d want 3", grant_log.size() > 0 ? grant_log[0] : -1); else n_pass++;
        n_checks++; if (grant_log.size() < 2 || grant_log[1] !== 1) $display("FAIL wrap_grant1 got %0d want 1", grant_log.size() > 1 ? grant_log[1] : -1); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            e = pop_exp();
            o = pop_obs();
            n_checks++; if (o !== e) $display("FAIL wrap_rsp%0d got id=%0d prod=%0d want id=%0d prod=%0d", k, o.id, o.product, e.id, e.product); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0;
        rv = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_req(i, '0, '0);
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish within 500000 time units");
        $fatal(1);
    end

endmodule
